// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Next index in round-robin order, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake bundle plus the FIFO write port it feeds.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  localparam int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_last;
  logic [NREQ-1:0][DSIZE-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       wfull;
  logic                       winc;
  logic [IDW+DSIZE-1:0]       wdata;

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after ptr, wrapping.
module rr_pick import fifo_arb_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);
  int idx;

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = int'(ptr);
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_next(idx, NREQ);
      if (!any && req[idx[IDW-1:0]]) begin
        any    = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NREQ requesters.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int  NREQ      = 4,
  parameter int  DSIZE     = 8,
  parameter int  MAX_BURST = 4,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic            wclk,
  input  logic            wrst_n,
  fifo_wr_arbiter_if.slave bus,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic [15:0]     xfer_cnt
);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [BW-1:0]  beat_cnt;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           beat;
  logic           burst_end;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Ready/winc stay combinational so a beat is accepted in the same cycle.
  always_comb begin
    bus.req_ready = '0;
    if (state == BURST && !bus.wfull) bus.req_ready[grant_id] = 1'b1;
  end

  assign beat      = (state == BURST) && bus.req_valid[grant_id] && !bus.wfull;
  assign burst_end = bus.req_last[grant_id] || (beat_cnt == BW'(MAX_BURST - 1));
  assign bus.winc  = beat;
  assign bus.wdata = {grant_id, bus.req_data[grant_id]};
  assign busy      = (state == BURST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NREQ - 1);
      grant_id <= '0;
      beat_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          grant_id <= pick_id;
          beat_cnt <= '0;
          state    <= BURST;
        end
        BURST: if (beat) begin
          xfer_cnt <= xfer_cnt + 16'd1;
          beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: handshake, round-robin, stall, gap and reset.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DSIZE = 8, MAX_BURST = 4, IDW = 2;

  logic            wclk = 1'b0;
  logic            wrst_n = 1'b0;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [15:0]     xfer_cnt;
  int              ntests = 0;
  int              nfail  = 0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #10 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Beat in progress from requester g with payload d.
  task automatic chk_beat(input string tag, input int g, input logic [7:0] d);
    #1;
    chk({tag, ".winc"}, 32'(bus.winc), 1);
    chk({tag, ".grant"}, 32'(grant_id), 32'(g));
    chk({tag, ".wdata"}, 32'(bus.wdata), 32'(g * 256 + int'(d)));
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(1 << g));
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".winc"}, 32'(bus.winc), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".ready"}, 32'(bus.req_ready), 0);
  endtask

  initial begin
    int order [5];
    order = '{3, 0, 1, 2, 3};
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;

    // Reset state
    #5;
    chk_idle("rst");
    chk("rst.xfer", 32'(xfer_cnt), 0);
    chk("rst.grant", 32'(grant_id), 0);
    #10 wrst_n = 1'b1;
    tick();

    // Single requester 2, 3-beat packet, last on the third
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = 8'hA1;
    chk_idle("t1.idle");
    tick();
    chk_beat("t1.b1", 2, 8'hA1);
    chk("t1.busy", 32'(busy), 1);
    tick();
    bus.req_data[2] = 8'hA2;
    chk_beat("t1.b2", 2, 8'hA2);
    tick();
    bus.req_data[2] = 8'hA3;
    bus.req_last[2] = 1'b1;
    chk_beat("t1.b3", 2, 8'hA3);
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;
    chk_idle("t1.end");
    chk("t1.xfer", 32'(xfer_cnt), 3);

    // All valid, never last: rr_ptr=2 so order is 3,0,1,2,3, 4 beats + 1 idle each
    for (int i = 0; i < NREQ; i++) bus.req_data[i] = 8'(8'h10 + i);
    bus.req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      chk_idle($sformatf("t2.g%0d.idle", g));
      tick();
      for (int b = 0; b < MAX_BURST; b++) begin
        chk_beat($sformatf("t2.g%0d.b%0d", g, b), order[g], 8'(8'h10 + order[g]));
        tick();
      end
    end
    bus.req_valid = '0;
    chk_idle("t2.end");
    chk("t2.xfer", 32'(xfer_cnt), 23);

    // wfull stall after beat 2 of 4 on requester 0
    bus.req_valid[0] = 1'b1;
    bus.req_data[0]  = 8'h31;
    chk_idle("t3.idle");
    tick();
    chk_beat("t3.b1", 0, 8'h31);
    tick();
    bus.req_data[0] = 8'h32;
    chk_beat("t3.b2", 0, 8'h32);
    tick();
    bus.wfull = 1'b1;
    bus.req_data[0] = 8'h33;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3.stall.winc", 32'(bus.winc), 0);
      chk("t3.stall.ready", 32'(bus.req_ready), 0);
      chk("t3.stall.busy", 32'(busy), 1);
      chk("t3.stall.xfer", 32'(xfer_cnt), 25);
      tick();
    end
    bus.wfull = 1'b0;
    chk_beat("t3.b3", 0, 8'h33);
    tick();
    bus.req_data[0] = 8'h34;
    chk_beat("t3.b4", 0, 8'h34);
    tick();
    bus.req_valid = '0;
    chk_idle("t3.end");
    chk("t3.xfer", 32'(xfer_cnt), 27);

    // Requester 1 drops valid mid-burst while 3 waits; full 4-beat burst still allowed
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    bus.req_data[1]  = 8'h51;
    bus.req_data[3]  = 8'h43;
    chk_idle("t4.idle");
    tick();
    chk_beat("t4.b1", 1, 8'h51);
    tick();
    bus.req_valid[1] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t4.gap.winc", 32'(bus.winc), 0);
      chk("t4.gap.grant", 32'(grant_id), 1);
      chk("t4.gap.ready", 32'(bus.req_ready), 32'h2);
      tick();
    end
    bus.req_valid[1] = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      bus.req_data[1] = 8'(8'h50 + b);
      chk_beat($sformatf("t4.b%0d", b), 1, 8'(8'h50 + b));
      tick();
    end
    bus.req_valid[1] = 1'b0;
    chk_idle("t4.rel");
    tick();
    bus.req_last[3] = 1'b1;
    chk_beat("t4.r3", 3, 8'h43);
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;
    chk_idle("t4.end");
    chk("t4.xfer", 32'(xfer_cnt), 32);

    // Reset mid-burst on requester 2, then 0 beats 2 from the reset pointer
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = 8'h61;
    tick();
    chk_beat("t5.b1", 2, 8'h61);
    tick();
    wrst_n = 1'b0;
    chk_idle("t5.rst");
    chk("t5.rst.xfer", 32'(xfer_cnt), 0);
    chk("t5.rst.grant", 32'(grant_id), 0);
    bus.req_valid[0] = 1'b1;
    bus.req_data[0]  = 8'h70;
    #2 wrst_n = 1'b1;
    tick();
    chk_beat("t5.win0", 0, 8'h70);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side scheduler that shares the single write port of the dual-clock async FIFO among NREQ requesters in the wclk domain. It round-robin arbitrates between valid/ready requesters and holds the grant for a burst of up to MAX_BURST beats, or until the requester marks its last beat. It drives winc/wdata into the FIFO, back-pressures from wfull, and tags each word with the source ID. Reader-side logic demultiplexes on the tag.

## Interface
- NREQ, 4: number of requesters (2..16).
- DSIZE, 8: payload width per requester.
- MAX_BURST, 4: maximum beats per grant (1..256).
- IDW, $clog2(NREQ): source-tag width (derived; do not override).
- wclk  in  1: write-domain clock.
- wrst_n  in  1: reset, asynchronous, active-low.
- req_valid  in  NREQ: per-requester data valid.
- req_last  in  NREQ: beat is the last of the requester's packet.
- req_data  in  NREQ*DSIZE: requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ: one-hot or zero; beat i transfers when req_valid[i] & req_ready[i].
- wfull  in  1: FIFO full flag (registered in FIFO, wclk domain).
- winc  out  1: FIFO write strobe.
- wdata  out  IDW+DSIZE: {source_id, payload} to FIFO.
- grant_id  out  IDW: currently/last granted requester.
- busy  out  1: high in BURST state.
- xfer_cnt  out  16: total accepted beats, wraps at 2^16.

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid, pick the winner combinationally, scanning from rr_ptr+1 upward modulo NREQ. Register grant_id = winner and beat_cnt = 0, then go to BURST. No transfer occurs in IDLE. If no req_valid, stay.
- BURST: req_ready[grant_id] = !wfull; all other ready bits are 0. winc = req_valid[grant_id] & !wfull. wdata = {grant_id, req_data[grant_id]}.
- On a beat (winc=1): xfer_cnt+1, beat_cnt+1.
- On a beat with req_last[grant_id], or with beat_cnt == MAX_BURST-1: set rr_ptr = grant_id, go to IDLE.
- Granted requester deasserts valid mid-burst: the grant is held and no beat counts. Requesters must not abandon a burst; there is no timeout.
- wfull=1: winc=0 and req_ready=0; state and counters are frozen.
- A single requester re-requesting after release regains the grant after one IDLE cycle.
- Reset (any time, including mid-burst): state=IDLE, rr_ptr=NREQ-1 (requester 0 has first priority), grant_id=0, beat_cnt=0, xfer_cnt=0. Outputs winc=0, req_ready=0, busy=0. An in-flight beat is not written.

## Timing
- winc/req_ready are combinational from registered state plus wfull/req_valid. Zero-cycle accept in BURST.
- First beat is accepted 1 cycle after req_valid rises in IDLE.
- Fairness overhead: one IDLE cycle per grant. Back-to-back maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- wfull is current for the cycle: the FIFO asserts it the cycle after the filling write, so no extra guard cycle is required.
- All state registers use posedge wclk, negedge wrst_n.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a helper function for next-in-round-robin order.
- Sub-module rr_pick: combinational round-robin priority selector with inputs req[NREQ] and ptr, outputs gnt_id and any.
- The top holds the FSM, beat/xfer counters, and the data mux.

## Test plan
- Single requester 2, 3-beat packet (data 0xA1, 0xA2, 0xA3, last on the third) → winc for 3 cycles starting 1 cycle after valid. wdata = {2'd2, 0xA1..0xA3}. xfer_cnt = 3. Return to IDLE.
- All 4 requesters continuously valid, never last, MAX_BURST=4 → grants 0,1,2,3,0. Each grant gives exactly 4 beats followed by 1 IDLE cycle.
- wfull forced high for 5 cycles mid-burst (beat 2 of 4) → winc=0 and ready=0 during the stall. Burst resumes with beat 3; no beat is lost or duplicated.
- Granted requester 1 drops valid for 3 cycles mid-burst while requester 3 is valid → grant stays on 1 and beat_cnt is unchanged. Requester 3 is granted only after requester 1's last beat.
- wrst_n asserted mid-burst on requester 2 → next cycle: state IDLE, winc=0, xfer_cnt=0. After release, requester 0 wins over 2 when both are valid.
- End-to-end with the async FIFO (wclk 20 ns, rclk 70 ns), 4 requesters × 16 random beats → reader receives each source's payloads in order, per tag, with no loss.
